// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the line word-select helper.
package fetch_pkg;

    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFF_W          = 2;

    // Word 0 occupies the most significant 32 bits of the line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  idx);
        return line[(LINE_W-1) - WORD_W*int'(idx) -: WORD_W];
    endfunction

endpackage

// File: rtl/ifq_line_fifo.sv
// Line storage for the fetch queue: circular buffer with count and synchronous flush.
module ifq_line_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    output logic [LINE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_fire, rd_fire;

    assign full_o    = (cnt_q == CntW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign wr_fire   = wr_en_i && !full_o && !flush_i;
    assign rd_fire   = rd_en_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointer/count next state; flush discards everything without touching storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_fire && !rd_fire) cnt_d = cnt_q + 1'b1;
            if (!wr_fire && rd_fire) cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Line storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/i_fetch_queue.sv
// Instruction fetch queue: requests I-cache lines, buffers them and hands out one
// instruction per cycle to dispatch; redirects flush and restart at the target.
module i_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       Pc_in,
    output logic              Rd_en,
    input  logic [LINE_W-1:0] Dout,
    input  logic              Dout_valid,
    input  logic              jmp_branch_valid,
    input  logic [31:0]       jmp_branch_address,
    input  logic              Dispatch_ren,
    output logic [31:0]       Ifetch_instruction,
    output logic [31:0]       Ifetch_pc_plus_4,
    output logic              Ifetch_empty
);

    logic [27:0]       fetch_line_q, fetch_line_d;
    logic [OFF_W-1:0]  head_off_q, head_off_d;
    logic [29:0]       head_pc_q, head_pc_d;
    logic [LINE_W-1:0] head_line;
    logic              full, empty;
    logic              accept, pop, retire;
    logic              unused_addr;

    assign unused_addr = ^jmp_branch_address[1:0];

    // Reset gates the request so the I-cache sees no read while reset is held.
    assign Rd_en  = reset && !full && !jmp_branch_valid;
    assign accept = Rd_en && Dout_valid;
    assign pop    = Dispatch_ren && !empty && !jmp_branch_valid;
    assign retire = pop && (head_off_q == OFF_W'(WORDS_PER_LINE - 1));

    ifq_line_fifo #(
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_en_i   (accept),
        .wr_data_i (Dout),
        .rd_en_i   (retire),
        .flush_i   (jmp_branch_valid),
        .rd_data_o (head_line),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign Pc_in              = {fetch_line_q, 4'b0000};
    assign Ifetch_empty       = empty;
    assign Ifetch_instruction = line_word(head_line, head_off_q);
    assign Ifetch_pc_plus_4   = {head_pc_q, 2'b00} + 32'd4;

    // Fetch address and head tracking; a redirect overrides accept and pop.
    always_comb begin
        fetch_line_d = fetch_line_q;
        head_off_d   = head_off_q;
        head_pc_d    = head_pc_q;
        if (jmp_branch_valid) begin
            fetch_line_d = jmp_branch_address[31:4];
            head_off_d   = jmp_branch_address[3:2];
            head_pc_d    = jmp_branch_address[31:2];
        end else begin
            if (accept) fetch_line_d = fetch_line_q + 28'd1;
            if (pop) begin
                head_pc_d  = head_pc_q + 30'd1;
                head_off_d = retire ? '0 : head_off_q + 1'b1;
            end
        end
    end

    // Fetch and head registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_line_q <= RESET_PC[31:4];
            head_off_q   <= RESET_PC[3:2];
            head_pc_q    <= RESET_PC[31:2];
        end else begin
            fetch_line_q <= fetch_line_d;
            head_off_q   <= head_off_d;
            head_pc_q    <= head_pc_d;
        end
    end

endmodule

// File: tb/tb_i_fetch_queue.sv
// Self-checking bench for i_fetch_queue against a line-queue reference model.
module tb_i_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk;
    logic         reset;
    logic [31:0]  Pc_in;
    logic         Rd_en;
    logic [127:0] Dout;
    logic         Dout_valid;
    logic         jmp_branch_valid;
    logic [31:0]  jmp_branch_address;
    logic         Dispatch_ren;
    logic [31:0]  Ifetch_instruction;
    logic [31:0]  Ifetch_pc_plus_4;
    logic         Ifetch_empty;

    i_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Pc_in              (Pc_in),
        .Rd_en              (Rd_en),
        .Dout               (Dout),
        .Dout_valid         (Dout_valid),
        .jmp_branch_valid   (jmp_branch_valid),
        .jmp_branch_address (jmp_branch_address),
        .Dispatch_ren       (Dispatch_ren),
        .Ifetch_instruction (Ifetch_instruction),
        .Ifetch_pc_plus_4   (Ifetch_pc_plus_4),
        .Ifetch_empty       (Ifetch_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered line base addresses plus the head word offset.
    logic [31:0] m_lines[$];
    logic [31:0] m_fetch;
    logic [31:0] m_head_pc;
    int          m_off;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a >> 2) ^ 32'hA500_0000;
    endfunction

    function automatic logic [127:0] line_at(input logic [31:0] a);
        return {word_at(a), word_at(a + 32'd4), word_at(a + 32'd8), word_at(a + 32'd12)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lines.delete();
        m_fetch   = {RESET_PC[31:4], 4'b0000};
        m_head_pc = {RESET_PC[31:2], 2'b00};
        m_off     = int'(RESET_PC[3:2]);
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en", 32'(Rd_en), 32'd0);
        check("rst_empty", 32'(Ifetch_empty), 32'd1);
        check("rst_pc_in", Pc_in, {RESET_PC[31:4], 4'b0000});
        check("rst_pc4", Ifetch_pc_plus_4, RESET_PC + 32'd4);
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance the model.
    task automatic do_cycle(input logic jmp, input logic [31:0] addr, input logic dv,
                            input logic ren);
        logic exp_rd, acc, pp;
        jmp_branch_valid   = jmp;
        jmp_branch_address = addr;
        Dout_valid         = dv;
        Dispatch_ren       = ren;
        Dout               = line_at(m_fetch);
        #2;
        exp_rd = !jmp && (m_lines.size() < DEPTH);
        check("rd_en", 32'(Rd_en), 32'(exp_rd));
        check("pc_in", Pc_in, m_fetch);
        check("empty", 32'(Ifetch_empty), 32'(m_lines.size() == 0));
        check("pc_plus_4", Ifetch_pc_plus_4, m_head_pc + 32'd4);
        if (m_lines.size() > 0)
            check("instr", Ifetch_instruction, word_at(m_lines[0] + 32'(4 * m_off)));
        acc = exp_rd && dv;
        pp  = ren && !jmp && (m_lines.size() > 0);
        @(posedge clk);
        #1;
        if (jmp) begin
            m_lines.delete();
            m_fetch   = {addr[31:4], 4'b0000};
            m_head_pc = {addr[31:2], 2'b00};
            m_off     = int'(addr[3:2]);
        end else begin
            if (pp) begin
                m_head_pc = m_head_pc + 32'd4;
                if (m_off == 3) begin
                    void'(m_lines.pop_front());
                    m_off = 0;
                end else begin
                    m_off++;
                end
            end
            if (acc) begin
                m_lines.push_back(m_fetch);
                m_fetch = m_fetch + 32'd16;
            end
        end
    endtask

    initial begin
        reset              = 1'b0;
        Dout               = '0;
        Dout_valid         = 1'b0;
        jmp_branch_valid   = 1'b0;
        jmp_branch_address = '0;
        Dispatch_ren       = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Dispatch stalled: fill to DEPTH lines, then pop through the head line.
        repeat (6) do_cycle(1'b0, '0, 1'b1, 1'b0);
        check("full_pc_in", Pc_in, 32'h0000_0040);
        repeat (4) do_cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0);

        // Sustained streaming.
        repeat (20) do_cycle(1'b0, '0, 1'b1, 1'b1);

        // Mid-line redirect into a partially full queue.
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        do_cycle(1'b1, 32'h0000_0108, 1'b1, 1'b1);
        check("redir_pc_in", Pc_in, 32'h0000_0100);
        repeat (6) do_cycle(1'b0, '0, 1'b1, 1'b1);

        // Cache stall with request held.
        repeat (3) do_cycle(1'b0, '0, 1'b0, 1'b0);
        repeat (3) do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Redirect colliding with accept and pop, then back-to-back redirects.
        do_cycle(1'b1, 32'h0000_2004, 1'b1, 1'b1);
        do_cycle(1'b1, 32'h0000_300F, 1'b1, 1'b1);
        repeat (8) do_cycle(1'b0, '0, 1'b1, 1'b1);

        // Fetch address wrap at the top of memory.
        do_cycle(1'b1, 32'hFFFF_FFE8, 1'b1, 1'b0);
        repeat (8) do_cycle(1'b0, '0, 1'b1, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic        jmp, dv, ren;
            logic [31:0] addr;
            jmp  = ($urandom_range(0, 15) == 0);
            addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3F))
                                               : $urandom;
            dv   = ($urandom_range(0, 3) != 0);
            ren  = ($urandom_range(0, 2) != 0);
            do_cycle(jmp, addr, dv, ren);
        end

        // Asynchronous reset mid-stream.
        repeat (3) do_cycle(1'b0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        repeat (10) do_cycle(1'b0, '0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i_fetch_queue.md
# i_fetch_queue

Instruction fetch queue: the requesting end of the I-cache line interface. It drives the fetch address and read enable into the I-cache, buffers returned 128-bit lines (four instructions each), and presents one instruction per cycle to dispatch with its PC+4. Branch/jump redirects flush the queue and restart fetch at the target, honouring mid-line target offsets.

## Interface

Parameters:
- `DEPTH`, 4: queue capacity in cache lines; power of 2, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch/head address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `Pc_in`  out  32  line fetch address to the I-cache, always {fetch_line, 4'b0}.
- `Rd_en`  out  1  line read request to the I-cache.
- `Dout`  in  128  returned line; word 0 at [127:96], word 3 at [31:0].
- `Dout_valid`  in  1  `Dout` valid this cycle.
- `jmp_branch_valid`  in  1  redirect request.
- `jmp_branch_address`  in  32  redirect target; bits [1:0] ignored.
- `Dispatch_ren`  in  1  pop the head instruction.
- `Ifetch_instruction`  out  32  head instruction; combinational from the head line and word offset.
- `Ifetch_pc_plus_4`  out  32  head_pc + 4.
- `Ifetch_empty`  out  1  no valid instruction at the head.

## Operation

- State:
  - line storage DEPTH×128.
  - wr_ptr/rd_ptr, log2(DEPTH) bits each, natural wrap.
  - count, log2(DEPTH)+1 bits.
  - fetch_line [31:4].
  - head_off [1:0], the word offset within the head line.
  - head_pc [31:2].
- full = (count == DEPTH). empty = (count == 0). `Ifetch_empty` = empty.
- `Rd_en` = !full && !jmp_branch_valid. There is no look-ahead: a same-cycle pop does not un-full the queue.
- Line accept: when `Rd_en` and `Dout_valid` are both high, write `Dout` at wr_ptr, increment wr_ptr and count, and add 1 to fetch_line (wraps at 2^28).
- If `Rd_en` is high and `Dout_valid` is low, nothing is written and the same `Pc_in` is held for retry.
- Pop: when `Dispatch_ren` and !empty, increment head_pc (the output advances by 4).
  - If head_off==3: advance rd_ptr, decrement count, head_off←0.
  - Otherwise head_off++.
  - `Dispatch_ren` while empty is ignored.
- Simultaneous line accept and line-retiring pop: count is unchanged and both pointers advance.
- Redirect (`jmp_branch_valid`) has priority over everything in that cycle. No write and no pop occur. Then:
  - count←0 and rd_ptr←wr_ptr.
  - fetch_line←addr[31:4].
  - head_off←addr[3:2].
  - head_pc←addr[31:2].
  - Fetch resumes the next cycle.
- Only the first line after a redirect starts mid-line. Words before head_off are skipped and never presented.
- Back-to-back redirects: the last one wins.

## Timing

- Reset values (while `reset`==0):
  - `Rd_en`=0.
  - `Ifetch_empty`=1.
  - `Pc_in`={RESET_PC[31:4],4'b0}.
  - `Ifetch_pc_plus_4`=RESET_PC+4.
  - Counters and pointers 0; head_off=RESET_PC[3:2].
  - `Ifetch_instruction` is don't-care while empty.
- First cycle after reset release: `Rd_en`=1. The I-cache answers combinationally in the same cycle.
- Fetch-to-dispatch latency: a line accepted at edge N makes `Ifetch_empty`=0 after edge N. The first instruction is poppable in cycle N+1.
- Sustained throughput: 1 line/cycle in, 1 instruction/cycle out. The queue fills in DEPTH cycles if dispatch stalls.
- Redirect asserted in cycle R: outputs show empty from R+1. The first target line can be accepted in R+1, and the target instruction is visible in R+2.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Partially consumed lines are discarded.

## Structure

- Shared package `fetch_pkg`: LINE_W=128, WORD_W=32, WORDS_PER_LINE=4, OFF_W=2, and the word-select helper (word i at [127-32i -: 32]). The I-cache and dispatch also use these.
- One natural sub-module: `ifq_line_fifo`, a DEPTH×LINE_W storage with pointers, count, full/empty and a synchronous flush. `i_fetch_queue` adds the fetch PC, head offset/PC and redirect control on top.

## Test plan

- Reset with RESET_PC=0, cache model returning line k as words {4k,4k+1,4k+2,4k+3}, `Dispatch_ren`=1 always → instructions 0,1,2,… one per cycle; `Ifetch_pc_plus_4`=4,8,12,…; `Ifetch_empty` low from cycle 2 on.
- Dispatch stalled → after DEPTH accepted lines `Rd_en`=0 and `Pc_in`=0x40 held. A single pop of word 3 of the head line does not raise `Rd_en` in the same cycle; it rises the next cycle.
- Redirect to 0x0000_0108 while the queue is partially full → empty the next cycle, `Pc_in`=0x100. The first instruction presented is word 2 of line 0x100, with `Ifetch_pc_plus_4`=0x10C, followed by word 3 and then line 0x110 word 0.
- `Dout_valid` held low 3 cycles with `Rd_en` high → `Pc_in` stable, count unchanged, no spurious write.
- Redirect together with `Dispatch_ren` and a line accept in the same cycle → no pop and no write; the new target wins. Back-to-back redirects → only the second target is fetched.
- `reset` asserted low mid-stream → `Rd_en`=0 and `Ifetch_empty`=1 immediately. After release, fetch restarts at RESET_PC.
